// File: rtl/full_adder.sv
// One-bit full adder built from two half adders, with an optional registered
// copy of sum/carry captured on clock edges where en is high.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module full_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic en,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q
);

  logic ha1_sum;
  logic ha1_carry;
  logic ha2_sum;
  logic ha2_carry;

  half_adder u_ha1 (
    .a     (a),
    .b     (b),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  half_adder u_ha2 (
    .a     (ha1_sum),
    .b     (c),
    .sum   (ha2_sum),
    .carry (ha2_carry)
  );

  // The two half-adder carries can never both be 1, so OR equals their sum.
  assign sum   = ha2_sum;
  assign carry = ha1_carry | ha2_carry;

  // Stage p0 -> registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (en) begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: truth-table vectors plus hand-written
// sequences for capture, enable hold and asynchronous reset behaviour.

module tb_full_adder;

  logic clk;
  logic rst_n;
  logic a, b, c, en;
  logic sum, carry, sum_q, carry_q;

  logic ha_a, ha_b, ha_sum, ha_carry;

  int vectors;
  int miscompares;

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic exp_carry;
    logic exp_sum;
  } fa_vec_t;

  typedef struct {
    logic a;
    logic b;
    logic exp_carry;
    logic exp_sum;
  } ha_vec_t;

  fa_vec_t fa_tbl[8];
  ha_vec_t ha_tbl[4];

  full_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .c       (c),
    .en      (en),
    .sum     (sum),
    .carry   (carry),
    .sum_q   (sum_q),
    .carry_q (carry_q)
  );

  half_adder u_ha (
    .a     (ha_a),
    .b     (ha_b),
    .sum   (ha_sum),
    .carry (ha_carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int fa_fail;
    vectors     = 0;
    miscompares = 0;

    fa_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fa_tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    fa_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    fa_tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    fa_tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    fa_tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    fa_tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    fa_tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    ha_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    ha_tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
    ha_tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
    ha_tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b1;
    en    = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    c     = 1'b0;
    ha_a  = 1'b0;
    ha_b  = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_sum_q", sum_q, 1'b0);
    check("reset_carry_q", carry_q, 1'b0);

    // Exhaustive combinational table; any miscompare stops the run
    fa_fail = miscompares;
    for (int i = 0; i < 8; i++) begin
      a = fa_tbl[i].a;
      b = fa_tbl[i].b;
      c = fa_tbl[i].c;
      #1;
      check($sformatf("fa_sum_%0d", i), sum, fa_tbl[i].exp_sum);
      check($sformatf("fa_carry_%0d", i), carry, fa_tbl[i].exp_carry);
    end
    if (miscompares != fa_fail) begin
      $display("FAIL exhaustive_table: %0d entries wrong, required 0", miscompares - fa_fail);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "combinational truth table wrong");
    end

    // Half adder standalone
    for (int i = 0; i < 4; i++) begin
      ha_a = ha_tbl[i].a;
      ha_b = ha_tbl[i].b;
      #1;
      check($sformatf("ha_sum_%0d", i), ha_sum, ha_tbl[i].exp_sum);
      check($sformatf("ha_carry_%0d", i), ha_carry, ha_tbl[i].exp_carry);
    end

    // Reset held across clock edges with en=1: registers stay clear
    a  = 1'b1;
    b  = 1'b1;
    c  = 1'b1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_sum_q", sum_q, 1'b0);
    check("held_reset_carry_q", carry_q, 1'b0);

    // Registered capture of 1/1
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_edge_sum_q", sum_q, 1'b0);
    check("pre_edge_carry_q", carry_q, 1'b0);
    @(posedge clk);
    #1;
    check("capture_sum_q", sum_q, 1'b1);
    check("capture_carry_q", carry_q, 1'b1);

    // Enable hold for 3 edges while inputs go to 0
    @(negedge clk);
    en = 1'b0;
    a  = 1'b0;
    b  = 1'b0;
    c  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum_q", sum_q, 1'b1);
    check("hold_carry_q", carry_q, 1'b1);
    check("hold_sum", sum, 1'b0);
    check("hold_carry", carry, 1'b0);

    // Inputs changing between edges do not reach the registers
    @(negedge clk);
    en = 1'b1;
    a  = 1'b1;
    b  = 1'b0;
    c  = 1'b0;
    #2;
    check("mid_cycle_sum_q", sum_q, 1'b1);
    check("mid_cycle_carry_q", carry_q, 1'b1);
    check("mid_cycle_sum", sum, 1'b1);
    check("mid_cycle_carry", carry, 1'b0);
    @(posedge clk);
    #1;
    check("recapture_sum_q", sum_q, 1'b1);
    check("recapture_carry_q", carry_q, 1'b0);

    // Reload 1/1, then asynchronous reset between edges
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    c = 1'b1;
    @(posedge clk);
    #1;
    check("reload_sum_q", sum_q, 1'b1);
    check("reload_carry_q", carry_q, 1'b1);
    @(negedge clk);
    #2;
    a     = 1'b0;
    b     = 1'b1;
    c     = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum_q", sum_q, 1'b0);
    check("async_rst_carry_q", carry_q, 1'b0);
    check("in_rst_sum", sum, 1'b0);
    check("in_rst_carry", carry, 1'b1);

    // Reset release with en=1 captures on the first edge
    @(negedge clk);
    a     = 1'b1;
    b     = 1'b0;
    c     = 1'b0;
    en    = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_sum_q", sum_q, 1'b1);
    check("release_carry_q", carry_q, 1'b0);

    // Reset release with en=0 keeps the registers at 0
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    a     = 1'b1;
    b     = 1'b1;
    c     = 1'b1;
    en    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_en0_sum_q", sum_q, 1'b0);
    check("release_en0_carry_q", carry_q, 1'b0);
    check("release_en0_sum", sum, 1'b1);
    check("release_en0_carry", carry, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
